// File: rtl/aes_pkg.sv
// Shared constants and types for the AES-128 key schedule and round stages.
package aes_pkg;

  localparam int KEY_W = 128;
  localparam int IDX_W = 4;

  // Round constants consumed by key steps 0..9 (producing rk1..rk10).
  localparam logic [7:0] RCON [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Forward AES S-box, indexed by the input byte.
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

endpackage

// File: rtl/aes_key_expand_seq_if.sv
// Request and round-key stream between the key schedule and its neighbours.
//
// Handshake: a round key transfers on a rising clk edge where rk_valid and
// rk_ready are both high. Once rk_valid rises, rk_out and rk_idx stay stable
// and rk_valid stays high until that transfer happens. start is a request
// with no ready: it is taken only while the schedule is idle (busy low).
interface aes_key_expand_seq_if;
  import aes_pkg::*;

  logic               start;
  logic [KEY_W-1:0]   key_in;
  logic               busy;
  logic               rk_valid;
  logic               rk_ready;
  logic [KEY_W-1:0]   rk_out;
  logic [IDX_W-1:0]   rk_idx;
  logic               done;

  // Requester / round-key consumer side.
  modport master (
    output start, key_in, rk_ready,
    input  busy, rk_valid, rk_out, rk_idx, done
  );

  // Key schedule side.
  modport slave (
    input  start, key_in, rk_ready,
    output busy, rk_valid, rk_out, rk_idx, done
  );
endinterface

// File: rtl/aes_sbox.sv
// Combinational forward S-box: one byte in, one byte out.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  assign out_o = SBOX[in_i];

endmodule

// File: rtl/aes_key_expand_seq.sv
// Iterative AES-128 key schedule: holds one round key and steps it forward
// on each accepted handshake, streaming rk0..rkNR to the round datapath.
module aes_key_expand_seq
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  aes_key_expand_seq_if.slave   kx,
  output state_t                state_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR);

  state_t             state_q;
  logic [KEY_W-1:0]   rk_q;
  logic [IDX_W-1:0]   idx_q;
  logic               valid_q;
  logic               busy_q;
  logic               done_q;

  logic [31:0]        rot_word;
  logic [31:0]        sub_word;
  logic [7:0]         rcon_sel;
  logic [KEY_W-1:0]   rk_d;

  // RotWord: left byte rotate of the last word of the current key.
  assign rot_word = {rk_q[23:0], rk_q[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .in_i  (rot_word[8*g +: 8]),
      .out_o (sub_word[8*g +: 8])
    );
  end

  // Round constant for the step that produces rk(idx+1); unused at the last index.
  always_comb begin
    rcon_sel = 8'h00;
    if (idx_q < LAST_IDX) rcon_sel = RCON[idx_q];
  end

  // next_key: chained word XORs seeded by SubWord(RotWord(w3)) ^ rcon.
  always_comb begin
    logic [31:0] t, n0, n1, n2, n3;
    t    = sub_word ^ {rcon_sel, 24'h0};
    n0   = rk_q[127:96] ^ t;
    n1   = rk_q[95:64]  ^ n0;
    n2   = rk_q[63:32]  ^ n1;
    n3   = rk_q[31:0]   ^ n2;
    rk_d = {n0, n1, n2, n3};
  end

  // Control FSM and the single key register; done is a registered one-cycle pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rk_q    <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (kx.start) begin
            rk_q    <= kx.key_in;
            idx_q   <= '0;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (valid_q && kx.rk_ready) begin
            if (idx_q == LAST_IDX) begin
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              rk_q  <= rk_d;
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign kx.rk_out   = rk_q;
  assign kx.rk_idx   = idx_q;
  assign kx.rk_valid = valid_q;
  assign kx.busy     = busy_q;
  assign kx.done     = done_q;
  assign state_o     = state_q;

endmodule

// File: doc/aes_key_expand_seq.md
Name: aes_key_expand_seq

Overview:
Iterative AES-128 key schedule generator that streams round keys rk0..rk10 one per handshake to the encryption datapath. It sits directly upstream of the round stages. rk10 feeds the final round (SubBytes, ShiftRows, AddRoundKey, no MixColumns); rk1..rk9 feed the full rounds. It computes each key on the fly from the previous one, so only one 128-bit key register is held and no key RAM is needed.

Parameters:
NR, 10, number of rounds; last round-key index (AES-128 only; other values unsupported).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  synchronous, active-low reset.
start  input  1  one-cycle request to begin expansion of key_in; sampled only in IDLE.
key_in  input  128  cipher key; byte 0 is [127:120]; sampled on an accepted start.
busy  output  1  high from the cycle after an accepted start until done.
rk_valid  output  1  rk_out/rk_idx hold a valid round key.
rk_ready  input  1  consumer accepts the current round key when high together with rk_valid.
rk_out  output  128  current round key, same byte order as key_in.
rk_idx  output  4  index of rk_out, 0..NR.
done  output  1  one-cycle pulse after rk_idx=NR is accepted.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-low (rst_n), applied only on the rising edge of clk.
- Reset values: state=IDLE, busy=0, rk_valid=0, rk_out=0, rk_idx=0, done=0.
- FSM has two states: IDLE and RUN.
- IDLE, start=1: load rk_out<=key_in, rk_idx<=0, rk_valid<=1, busy<=1, go to RUN. Latency from start to rk0 valid is 1 cycle.
- IDLE, start=0: hold. done is low except for its single pulse cycle.
- RUN, rk_valid & rk_ready & rk_idx<NR: rk_out<=next_key(rk_out, rcon[rk_idx]), rk_idx<=rk_idx+1, rk_valid stays 1.
- RUN, rk_valid & rk_ready & rk_idx==NR: rk_valid<=0, busy<=0, done<=1 for exactly one cycle, go to IDLE.
- RUN, rk_ready=0: rk_out and rk_idx hold stable. rk_valid stays 1 and never drops without a handshake.
- next_key: split the current key into words w0..w3 (w0=[127:96]). Then:
  - t = SubWord(RotWord(w3)) XOR {rcon,24'h0}. RotWord is a left byte rotate.
  - n0=w0^t, n1=w1^n0, n2=w2^n1, n3=w3^n2.
- rcon[i] for i=0..9: 01 02 04 08 10 20 40 80 1b 36.
- Throughput: with rk_ready held high, the keys come out on 11 consecutive cycles and done follows on the 12th cycle after start.
- start while busy: ignored; the key in progress is not disturbed.
- start in the same cycle as done: done is registered, so the FSM is already in IDLE and the start is accepted. The new rk0 is valid the next cycle.
- rst_n low mid-operation: return to reset values on the next edge. done is not asserted and the partial sequence is discarded.
- key_in may change after an accepted start without affecting output.
- No X propagation on rk_out while rk_valid=0; it retains its last value or 0 after reset.

Decomposition:
- Package aes_pkg holds: the RCON array (10 x 8-bit), the FSM state enum (IDLE, RUN), the widths (KEY_W=128, IDX_W=4), and the SBOX constant table (256 x 8-bit).
- One sub-module, aes_sbox: a combinational 8-bit in/8-bit out lookup. It is instantiated 4x for SubWord and is the same instance type as in the round stages.
- next_key is a combinational function or always block inside aes_key_expand_seq.

Test Plan:
1. FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, start pulse, rk_ready=1:
   - rk_idx=0 gives 2b7e151628aed2a6abf7158809cf4f3c.
   - rk_idx=1 gives a0fafe1788542cb123a339392a6c7605.
   - rk_idx=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6.
   - done pulses exactly once, 12 cycles after start.
2. Same key with rk_ready toggled pseudo-randomly: the sequence of accepted keys is identical to scenario 1, and rk_out stays stable through every ready=0 cycle.
3. All-zero key: rk1=62636363626363636263636362636363 and rk10=b4ef5bcb3e92e21123e951cf6f8f188e.
4. Second start pulse with key ffff...ff issued at rk_idx=5: it is ignored and the scenario-1 sequence completes unchanged.
5. rst_n low at rk_idx=4: the next cycle shows rk_valid=0, busy=0, rk_idx=0, rk_out=0, and no done pulse. A following start runs a clean full sequence.
6. start asserted in the done cycle: it is accepted, rk0 of the new key is valid the next cycle, and there is no idle gap beyond one cycle.
